// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry adder: STAGES registered SEG-bit carry segments
// behind a valid/ready handshake; optional ovf output under PRA_OVF_EN.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   in_valid/in_ready   operand handshake (in_ready = pipeline advance)
//   a, b, c_in          operands and carry into bit 0
//   out_valid/out_ready result handshake
//   sum, c_out          registered result and carry out of bit WIDTH-1
//   ovf                 signed overflow (only with PRA_OVF_EN)
module pipelined_rca_adder #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
`ifdef PRA_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int SEG = WIDTH / STAGES;

   logic adv;

   // Whole pipeline moves together; a stalled output freezes every stage.
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   function automatic logic [SEG:0] rca(
      input logic [SEG-1:0] x,
      input logic [SEG-1:0] y,
      input logic           ci
   );
      logic [SEG:0] r;
      logic         c;
      r = '0;
      c = ci;
      for (int i = 0; i < SEG; i++) begin
         r[i] = x[i] ^ y[i] ^ c;
         c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
      end
      r[SEG] = c;
      return r;
   endfunction

   for (genvar k = 0; k < STAGES; k++) begin : g_st
      localparam int LO = k * SEG;
      localparam int HI = LO + SEG;

      logic           v_d;
      logic           ci;
      logic [SEG-1:0] x;
      logic [SEG-1:0] y;
      logic [SEG:0]   res;
      logic [HI-1:0]  s_d;
      logic           v_q;
      logic           c_q;
      logic [HI-1:0]  s_q;

      if (k == 0) begin : g_src
         assign v_d = in_valid;
         assign ci  = c_in;
         assign x   = a[SEG-1:0];
         assign y   = b[SEG-1:0];
         assign s_d = res[SEG-1:0];
      end else begin : g_src
         assign v_d = g_st[k-1].v_q;
         assign ci  = g_st[k-1].c_q;
         assign x   = g_st[k-1].g_rem.ar_q[SEG-1:0];
         assign y   = g_st[k-1].g_rem.br_q[SEG-1:0];
         assign s_d = {res[SEG-1:0], g_st[k-1].s_q};
      end

      assign res = rca(x, y, ci);

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
            s_q <= '0;
         end else if (adv) begin
            v_q <= v_d;
            c_q <= res[SEG];
            s_q <= s_d;
         end
      end

      // Operand bits not yet added ride along; the last stage has none.
      if (HI < WIDTH) begin : g_rem
         localparam int RW = WIDTH - HI;

         logic [RW-1:0] ar_d;
         logic [RW-1:0] br_d;
         logic [RW-1:0] ar_q;
         logic [RW-1:0] br_q;

         if (k == 0) begin : g_fwd
            assign ar_d = a[WIDTH-1:HI];
            assign br_d = b[WIDTH-1:HI];
         end else begin : g_fwd
            assign ar_d = g_st[k-1].g_rem.ar_q[RW+SEG-1:SEG];
            assign br_d = g_st[k-1].g_rem.br_q[RW+SEG-1:SEG];
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               ar_q <= '0;
               br_q <= '0;
            end else if (adv) begin
               ar_q <= ar_d;
               br_q <= br_d;
            end
         end
      end
   end

   assign out_valid = g_st[STAGES-1].v_q;
   assign sum       = g_st[STAGES-1].s_q;
   assign c_out     = g_st[STAGES-1].c_q;

`ifdef PRA_OVF_EN
   // Operand MSBs reach the last stage as its top segment bits.
   logic ovf_d;
   logic ovf_q;

   assign ovf_d =
      (g_st[STAGES-1].x[SEG-1] == g_st[STAGES-1].y[SEG-1]) &&
      (g_st[STAGES-1].res[SEG-1] != g_st[STAGES-1].x[SEG-1]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (adv) begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`endif

endmodule
